// File: rtl/oam_dma.sv
// oam_dma: sprite DMA that halts the CPU and copies a 256-byte page to the OAM data port.
module oam_dma #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] DEST_ADDR = 16'h2004
) (
    input  logic        G_clock,
    input  logic        G_reset,
    input  logic [15:0] G_cpu_addr,
    input  logic [7:0]  G_cpu_wr_data,
    input  logic        G_cpu_rdwr,
    input  logic [7:0]  G_rd_data,
    output logic        G_ready,
    output logic        G_dma_active,
    output logic [15:0] G_dma_addr,
    output logic [7:0]  G_dma_wr_data,
    output logic        G_dma_rdwr
);
    typedef enum logic [2:0] {IDLE, WAIT, HALT, ALIGN, READ, WRITE} state_t;
    state_t state, state_n;
    logic [3:0] tick;
    logic parity, parity_n, trig_q, trig_cond, start, cycle_end;
    logic [7:0] idx, idx_n, page, page_n, data, data_n;
    logic active_n, is_wr;
    always_comb begin
        trig_cond = !G_cpu_rdwr && (G_cpu_addr == TRIG_ADDR);
        start = trig_cond && !trig_q;
        cycle_end = tick == 4'd11;
        parity_n = parity ^ cycle_end;
    end
    always_comb begin
        state_n = state;
        idx_n = idx;
        page_n = page;
        data_n = data;
        case (state)
            IDLE: if (start) begin
                state_n = WAIT;
                page_n = G_cpu_wr_data;
            end
            WAIT: if (cycle_end) state_n = HALT;
            HALT: if (cycle_end) state_n = parity_n ? ALIGN : READ;
            ALIGN: if (cycle_end) state_n = READ;
            READ: if (cycle_end) begin
                state_n = WRITE;
                data_n = G_rd_data;
            end
            WRITE: if (cycle_end) begin
                idx_n = idx + 8'd1;
                state_n = (idx == 8'hFF) ? IDLE : READ;
            end
            default: state_n = IDLE;
        endcase
        // outputs are derived from next-state values so they register in step with the state
        active_n = (state_n != IDLE) && (state_n != WAIT);
        is_wr = state_n == WRITE;
    end
    always_ff @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            state <= IDLE;
            tick <= 4'd0;
            parity <= 1'b0;
            trig_q <= 1'b0;
            idx <= 8'd0;
            page <= 8'd0;
            data <= 8'd0;
            G_ready <= 1'b1;
            G_dma_active <= 1'b0;
            G_dma_addr <= 16'd0;
            G_dma_wr_data <= 8'd0;
            G_dma_rdwr <= 1'b1;
        end else begin
            state <= state_n;
            tick <= cycle_end ? 4'd0 : tick + 4'd1;
            parity <= parity_n;
            trig_q <= trig_cond;
            idx <= idx_n;
            page <= page_n;
            data <= data_n;
            G_ready <= state_n == IDLE;
            G_dma_active <= active_n;
            G_dma_addr <= is_wr ? DEST_ADDR : (active_n ? {page_n, idx_n} : 16'd0);
            G_dma_wr_data <= is_wr ? data_n : 8'd0;
            G_dma_rdwr <= !is_wr;
        end
    end
endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have port G_clock  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port G_reset  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port G_cpu_addr  in  16  CPU address bus, taken straight from the CPU, not from the bus mux.
REQ-004 SHALL have port G_cpu_wr_data  in  8  CPU write data.
REQ-005 SHALL have port G_cpu_rdwr  in  1  CPU direction: 1 = read, 0 = write.
REQ-006 SHALL have port G_rd_data  in  8  system bus read data.
REQ-007 SHALL have port G_ready  out  1  CPU ready; low freezes the CPU.
REQ-008 SHALL have port G_dma_active  out  1  bus mux select; 1 = this block drives the bus.
REQ-009 SHALL have port G_dma_addr  out  16  DMA bus address.
REQ-010 SHALL have port G_dma_wr_data  out  8  DMA write data.
REQ-011 SHALL have port G_dma_rdwr  out  1  DMA direction: 1 = read, 0 = write.
REQ-012 SHALL have parameter TRIG_ADDR, default 16'h4014, meaning the trigger register address.
REQ-013 SHALL have parameter DEST_ADDR, default 16'h2004, meaning the OAM data port address.

Function
REQ-014 SHALL run a free-running tick counter 0..11 that wraps to 0; the tick at 11 is the cycle end, and one DMA cycle is 12 clocks.
REQ-015 SHALL toggle a parity bit at every cycle end, with parity 0 out of reset.
REQ-016 SHALL define the trigger condition as G_cpu_rdwr = 0 and G_cpu_addr = TRIG_ADDR, registered each clock.
REQ-017 SHALL start a transfer only on the rising edge of the trigger condition while IDLE; a level held high SHALL NOT retrigger.
REQ-018 SHALL latch page = G_cpu_wr_data on the triggering clock.
REQ-019 SHALL use states IDLE, WAIT, HALT, ALIGN, READ, WRITE.
REQ-020 SHALL go IDLE -> WAIT on the trigger; WAIT -> HALT at the next cycle end.
REQ-021 SHALL, from the clock after the trigger until DMA completion, drive G_ready = 0.
REQ-022 SHALL spend one full cycle in HALT; at its end go to ALIGN if parity is 1 after the toggle, otherwise to READ.
REQ-023 SHALL spend one cycle in ALIGN and then go to READ.
REQ-024 SHALL drive G_dma_active = 1 in HALT, ALIGN, READ and WRITE, and 0 in IDLE and WAIT.
REQ-025 SHALL, in HALT and ALIGN, drive G_dma_addr = {page, idx} with G_dma_rdwr = 1 (dummy read, data discarded).
REQ-026 SHALL, in READ, drive G_dma_addr = {page, idx} and G_dma_rdwr = 1, and capture G_rd_data into the data latch at the cycle end.
REQ-027 SHALL, in WRITE, drive G_dma_addr = DEST_ADDR, G_dma_wr_data = the data latch, and G_dma_rdwr = 0.
REQ-028 SHALL go READ -> WRITE at the cycle end.
REQ-029 SHALL, at a WRITE cycle end, increment idx (8 bits) and return to READ; when idx was 8'hFF, go instead to IDLE and wrap idx to 0.
REQ-030 SHALL, on entering IDLE, drive G_ready = 1, G_dma_active = 0 and G_dma_rdwr = 1 on the same clock.
REQ-031 SHALL take 513 cycles from HALT entry to IDLE with parity 0, and 514 with parity 1.
REQ-032 SHALL ignore trigger edges outside IDLE.
REQ-033 SHALL treat a read of TRIG_ADDR, or a write to any other address, as no trigger.
REQ-034 SHALL register all outputs; no combinational path from any input to any output.

Reset
REQ-035 SHALL, while G_reset = 0, immediately force: G_ready = 1, G_dma_active = 0, G_dma_addr = 0, G_dma_wr_data = 0, G_dma_rdwr = 1, state IDLE, tick 0, parity 0, idx 0, page 0, data latch 0, trigger history 0.
REQ-036 SHALL abort a transfer on reset mid-operation with no further bus cycles; the next transfer SHALL start at idx 0.

Verification
REQ-037 SHALL cover: assert G_reset = 0 for 3 clocks -> all outputs at the REQ-035 values; G_ready stays 1 for 100 clocks after release.
REQ-038 SHALL cover: CPU writes 8'h02 to 16'h4014 with parity 0 at HALT end, memory byte = low address byte -> 256 read/write pairs, reads at 16'h0200..16'h02FF, writes to 16'h2004 with data 8'h00..8'hFF; G_ready low for WAIT plus 513 cycles.
REQ-039 SHALL cover: same as REQ-038 with parity 1 -> one ALIGN dummy read at 16'h0200, then 514 cycles total.
REQ-040 SHALL cover: CPU reads 16'h4014, and writes 16'h4015 -> G_ready stays 1 and G_dma_active stays 0.
REQ-041 SHALL cover: reset asserted during READ of idx 8'h80 -> outputs at reset values on the same clock; a new write of 8'h03 then reads 16'h0300 first.
REQ-042 SHALL cover: trigger condition held high throughout a transfer and 5 cycles beyond -> exactly one transfer (256 writes).
